// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: register offsets,
// STATUS bit layout, default MMIO base, decode targets and the request bundle.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

    localparam logic [4:0] OFF_GPIO    = 5'h00;
    localparam logic [4:0] OFF_TXDATA  = 5'h04;
    localparam logic [4:0] OFF_STATUS  = 5'h08;
    localparam logic [4:0] OFF_CYCLE   = 5'h0C;
    localparam logic [4:0] OFF_TIMECMP = 5'h10;

    localparam int unsigned ST_EMPTY_BIT = 0;
    localparam int unsigned ST_FULL_BIT  = 1;
    localparam int unsigned ST_OVF_BIT   = 2;
    localparam int unsigned ST_COUNT_LSB = 4;
    localparam int unsigned ST_COUNT_W   = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_GPIO,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_TIMECMP
    } sel_e;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    function automatic logic [31:0] status_word(input logic empty, input logic full,
                                                input logic ovf, input logic [ST_COUNT_W-1:0] count);
        logic [31:0] w;
        w = '0;
        w[ST_EMPTY_BIT] = empty;
        w[ST_FULL_BIT]  = full;
        w[ST_OVF_BIT]   = ovf;
        w[ST_COUNT_LSB +: ST_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the TX consumer; head byte and valid are registered so they
// only move on clock edges. Overflow is sticky until explicitly cleared.
module tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [7:0]              push_data_i,
    input  logic                    pop_i,
    input  logic                    ovf_clr_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          do_push_c, do_pop_c, ovf_set_c;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop_c  = pop_i & ~empty_o;
        do_push_c = push_i & (~full_o | do_pop_c);
        ovf_set_c = push_i & full_o & ~do_pop_c;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
        ovf_d   = (ovf_q & ~ovf_clr_i) | ovf_set_c;

        // Next head: bypass the incoming byte when it lands in the head slot.
        data_d = data_q;
        if (count_d != '0) begin
            if (do_push_c && (rd_ptr_d == wr_ptr_q)) begin
                data_d = push_data_i;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c && !reset) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Zero-wait-state data memory: byte-laned RAM at address 0 plus an MMIO window
// (GPIO, TX FIFO, STATUS, optional timer enabled by DMEM_TIMER_EN).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_sig,
    input  logic [3:0]  mem_be,
    output logic [31:0] mem_rd_data,
    output logic        mem_err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int unsigned IW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    mem_req_t      req_c;
    sel_e          sel_c;
    logic [31:0]   mmio_off_c;
    logic [IW-1:0] ram_idx_c;
    logic          ram_we_c, mmio_we_c;
    logic          push_c, ovf_clr_c, err_d;
    logic [31:0]   cycle_rd_c, timecmp_rd_c;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [31:0]   gpio_q;
    logic          mem_err_q;

    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0] fifo_count;

    assign req_c = '{wr: mem_wr_sig, addr: mem_addr, wdata: mem_wr_data, be: mem_be};

    assign mmio_off_c = {req_c.addr[31:2], 2'b00} - MMIO_BASE;
    assign ram_idx_c  = req_c.addr[IW+1:2];

    // Address decode; RAM takes priority, the MMIO window is five consecutive words.
    always_comb begin
        sel_c = SEL_NONE;
        if ({2'b00, req_c.addr[31:2]} < 32'(RAM_WORDS)) begin
            sel_c = SEL_RAM;
        end else if (mmio_off_c[31:5] == '0) begin
            unique case (mmio_off_c[4:0])
                OFF_GPIO:    sel_c = SEL_GPIO;
                OFF_TXDATA:  sel_c = SEL_TXDATA;
                OFF_STATUS:  sel_c = SEL_STATUS;
                OFF_CYCLE:   sel_c = SEL_CYCLE;
                OFF_TIMECMP: sel_c = SEL_TIMECMP;
                default:     sel_c = SEL_NONE;
            endcase
        end
    end

    always_comb begin
        ram_we_c  = req_c.wr & ~reset & (sel_c == SEL_RAM);
        mmio_we_c = req_c.wr & ~reset;
        push_c    = mmio_we_c & (sel_c == SEL_TXDATA);
        ovf_clr_c = mmio_we_c & (sel_c == SEL_STATUS) & req_c.wdata[ST_OVF_BIT];
        err_d     = ~reset & (sel_c == SEL_NONE) & (req_c.wr | (req_c.addr != '0));
    end

    // Combinational read path: the CPU samples this in the same cycle.
    always_comb begin
        mem_rd_data = '0;
        unique case (sel_c)
            SEL_RAM:     mem_rd_data = ram_q[ram_idx_c];
            SEL_GPIO:    mem_rd_data = gpio_q;
            SEL_STATUS:  mem_rd_data = status_word(fifo_empty, fifo_full, fifo_ovf,
                                                   ST_COUNT_W'(fifo_count));
            SEL_CYCLE:   mem_rd_data = cycle_rd_c;
            SEL_TIMECMP: mem_rd_data = timecmp_rd_c;
            default:     mem_rd_data = '0;
        endcase
    end

    // RAM is intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (req_c.be[b]) begin
                    ram_q[ram_idx_c][b*8 +: 8] <= req_c.wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= err_d;
            if (mmio_we_c && (sel_c == SEL_GPIO)) begin
                gpio_q <= req_c.wdata;
            end
        end
    end

    assign gpio_out = gpio_q;
    assign mem_err  = mem_err_q;

`ifdef DMEM_TIMER_EN
    logic [31:0] cycle_q, timecmp_q;
    logic        irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            timecmp_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            irq_q   <= (cycle_q >= timecmp_q);
            if (mmio_we_c && (sel_c == SEL_TIMECMP)) begin
                timecmp_q <= req_c.wdata;
            end
        end
    end

    assign cycle_rd_c   = cycle_q;
    assign timecmp_rd_c = timecmp_q;
    assign timer_irq    = irq_q;
`else
    assign cycle_rd_c   = '0;
    assign timecmp_rd_c = '0;
    assign timer_irq    = 1'b0;
`endif

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_c),
        .push_data_i (req_c.wdata[7:0]),
        .pop_i       (tx_ready),
        .ovf_clr_i   (ovf_clr_c),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .overflow_o  (fifo_ovf)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a queue/array
// reference model; follows DMEM_TIMER_EN when it is defined for the build.
module tb_dmem_responder;

    localparam int unsigned RAM_WORDS  = 1024;
    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned MODEL_WDS  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data, gpio_out;
    logic        mem_wr_sig, mem_err, tx_valid, tx_ready, timer_irq;
    logic [3:0]  mem_be;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    dmem_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .MMIO_BASE  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_sig  (mem_wr_sig),
        .mem_be      (mem_be),
        .mem_rd_data (mem_rd_data),
        .mem_err     (mem_err),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .gpio_out    (gpio_out),
        .timer_irq   (timer_irq)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit rdy_g = 1'b0;

    // Reference state
    logic [31:0] ram_m [MODEL_WDS];
    logic [7:0]  q[$];
    logic [7:0]  txd_m;
    logic [31:0] gpio_m, cycle_m, tcmp_m;
    bit          ovf_m, err_m, irq_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return (a >> 2) < 32'(RAM_WORDS);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (is_ram(w)) return ram_m[w[5:2]];
        if (w == BASE) return gpio_m;
        if (w == BASE + 32'h8)
            return {24'h0, 4'(q.size()), 1'b0, ovf_m, q.size() == DEPTH, q.size() == 0};
`ifdef DMEM_TIMER_EN
        if (w == BASE + 32'hC)  return cycle_m;
        if (w == BASE + 32'h10) return tcmp_m;
`endif
        return 32'h0;
    endfunction

    task automatic model_step(input bit rst, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be, input bit rdy);
        logic [31:0] w;
        bit mapped, pop;
        int n;
        w = a & ~32'h3;
        if (rst) begin
            q.delete();
            txd_m = 8'h0; ovf_m = 0; gpio_m = 0; err_m = 0;
            cycle_m = 0; tcmp_m = 32'hFFFF_FFFF; irq_m = 0;
            return;
        end
        mapped = is_ram(w) || (w >= BASE && w <= BASE + 32'h10);
        err_m  = !mapped && (wr || a != 0);
        n   = q.size();
        pop = rdy && n > 0;
        if (pop) void'(q.pop_front());
        if (wr && w == BASE + 32'h4) begin
            if (n == DEPTH && !pop) ovf_m = 1;
            else q.push_back(d[7:0]);
        end
        if (q.size() > 0) txd_m = q[0];
        if (wr && w == BASE + 32'h8 && d[2]) ovf_m = 0;
        if (wr && w == BASE) gpio_m = d;
        if (wr && is_ram(w)) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ram_m[w[5:2]][b*8 +: 8] = d[b*8 +: 8];
        end
`ifdef DMEM_TIMER_EN
        irq_m   = cycle_m >= tcmp_m;
        cycle_m = cycle_m + 1;
        if (wr && w == BASE + 32'h10) tcmp_m = d;
`endif
    endtask

    // One bus cycle: drive at negedge, check the combinational read, then the registered outputs.
    task automatic step(input bit rst, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit lit_en, input logic [31:0] lit,
                        input string tag);
        @(negedge clk);
        reset = rst; mem_wr_sig = wr; mem_addr = a; mem_wr_data = d; mem_be = be;
        tx_ready = rdy_g;
        #1;
        check({tag, "_rd"}, mem_rd_data, model_read(a));
        if (lit_en) check({tag, "_lit"}, mem_rd_data, lit);
        model_step(rst, wr, a, d, be, rdy_g);
        @(posedge clk);
        #1;
        check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        check("tx_data", 32'(tx_data), 32'(txd_m));
        check("mem_err", 32'(mem_err), 32'(err_m));
        check("gpio_out", gpio_out, gpio_m);
        check("timer_irq", 32'(timer_irq), 32'(irq_m));
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, "idle");
    endtask
    task automatic wr_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        step(0, 1, a, d, be, 0, 32'h0, "wr");
    endtask
    task automatic rd_op(input logic [31:0] a);
        step(0, 0, a, 32'h0, 4'h0, 0, 32'h0, "rd");
    endtask
    task automatic rd_lit(input logic [31:0] a, input logic [31:0] lit, input string tag);
        step(0, 0, a, 32'h0, 4'h0, 1, lit, tag);
    endtask
    task automatic rst_op();
        step(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, "rst");
    endtask

    initial begin
        logic [31:0] a, d;
        int k;
        reset = 1'b1; mem_wr_sig = 0; mem_addr = 0; mem_wr_data = 0; mem_be = 0; tx_ready = 0;

        // Reset values
        rst_op(); rst_op();
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_txv", 32'(tx_valid), 32'h0);
        check("rst_txd", 32'(tx_data), 32'h0);
        rd_lit(BASE + 32'h8, 32'h1, "rst_status");

        for (int i = 0; i < MODEL_WDS; i++) wr_op(32'(i * 4), $urandom, 4'hF);

        // Lane-masked write
        wr_op(32'h10, 32'h0, 4'hF);
        wr_op(32'h10, 32'hDEADBEEF, 4'b0101);
        rd_lit(32'h10, 32'h00AD00EF, "be_mask");

        // Fill, overflow, clear, drain in order
        rdy_g = 0;
        for (int i = 0; i < 4; i++) wr_op(BASE + 32'h4, 32'h41 + 32'(i), 4'h0);
        rd_lit(BASE + 32'h8, 32'h42, "full_status");
        wr_op(BASE + 32'h4, 32'h45, 4'h0);
        rd_lit(BASE + 32'h8, 32'h46, "ovf_status");
        check("ovf_head", 32'(tx_data), 32'h41);
        wr_op(BASE + 32'h8, 32'h4, 4'h0);
        rd_lit(BASE + 32'h8, 32'h42, "ovf_clear");
        rdy_g = 1;
        for (int i = 1; i <= 4; i++) begin
            idle();
            if (i < 4) check("drain_head", 32'(tx_data), 32'h41 + 32'(i));
            else check("drain_empty", 32'(tx_valid), 32'h0);
        end
        check("empty_hold", 32'(tx_data), 32'h44);

        // Push and pop together on a full FIFO
        rdy_g = 0;
        for (int i = 0; i < 4; i++) wr_op(BASE + 32'h4, 32'h61 + 32'(i), 4'h0);
        rdy_g = 1;
        wr_op(BASE + 32'h4, 32'h55, 4'h0);
        rdy_g = 0;
        rd_lit(BASE + 32'h8, 32'h42, "pushpop_status");
        rdy_g = 1;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i == 2) check("pushpop_last", 32'(tx_data), 32'h55);
        end
        check("pushpop_empty", 32'(tx_valid), 32'h0);
        rdy_g = 0;

        // Unmapped write
        rd_op(32'h0);
        a = model_read(32'h0);
        wr_op(32'h0001_0000, 32'h1234, 4'hF);
        check("unmapped_err", 32'(mem_err), 32'h1);
        idle();
        check("unmapped_err_1cyc", 32'(mem_err), 32'h0);
        rd_lit(32'h0, a, "no_alias");
        rd_lit(32'h0001_0000, 32'h0, "unmapped_rd");

        // GPIO then reset: GPIO clears, RAM keeps its contents
        wr_op(BASE, 32'hA5A5A5A5, 4'h0);
        check("gpio_set", gpio_out, 32'hA5A5A5A5);
        rdy_g = 0;
        wr_op(BASE + 32'h4, 32'h77, 4'h0);
        step(1, 1, BASE + 32'h4, 32'h99, 4'h0, 0, 32'h0, "rst_wr");
        check("gpio_rst", gpio_out, 32'h0);
        check("fifo_rst", 32'(tx_valid), 32'h0);
        rd_lit(32'h10, 32'h00AD00EF, "ram_keep");

`ifdef DMEM_TIMER_EN
        rst_op();
        wr_op(BASE + 32'h10, 32'd20, 4'h0);
        while (cycle_m < 25) begin
            rd_op(BASE + 32'hC);
            if (cycle_m == 20) check("irq_before", 32'(timer_irq), 32'h0);
            if (cycle_m == 21) check("irq_rise", 32'(timer_irq), 32'h1);
        end
        rst_op();
        check("irq_rst", 32'(timer_irq), 32'h0);
        rd_lit(BASE + 32'hC, 32'h0, "cycle_rst");
`else
        wr_op(BASE + 32'h10, 32'd20, 4'h0);
        check("tcmp_noerr", 32'(mem_err), 32'h0);
        rd_lit(BASE + 32'h10, 32'h0, "tcmp_off");
        rd_lit(BASE + 32'hC, 32'h0, "cycle_off");
        check("irq_off", 32'(timer_irq), 32'h0);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rdy_g = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                step(1, 1'($urandom_range(0, 1)), BASE + 32'h4, $urandom, 4'hF, 0, 32'h0, "rnd_rst");
                continue;
            end
            k = $urandom_range(0, 9);
            d = $urandom;
            case (k)
                0, 1: rd_op(32'($urandom_range(0, 63)));
                2, 3: wr_op(32'($urandom_range(0, 63)), d, 4'($urandom_range(0, 15)));
                4: step(0, 1'($urandom_range(0, 1)), BASE | 32'($urandom_range(0, 3)), d, 4'h0, 0, 32'h0, "rnd_gpio");
                5, 6: wr_op(BASE + 32'h4 + 32'($urandom_range(0, 3)), d, 4'h0);
                7: step(0, 1'($urandom_range(0, 1)), BASE + 32'h8, d, 4'h0, 0, 32'h0, "rnd_status");
                8: begin
                    a = ($urandom_range(0, 1) == 1) ? BASE + 32'hC : BASE + 32'h10;
                    step(0, 1'($urandom_range(0, 1)), a, 32'($urandom_range(0, 800)), 4'h0, 0, 32'h0, "rnd_timer");
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0: a = BASE + 32'h14;
                        1: a = 32'h0001_0000;
                        default: a = 32'h8000_0000;
                    endcase
                    step(0, 1'($urandom_range(0, 1)), a | 32'($urandom_range(0, 3)), d, 4'hF, 0, 32'h0, "rnd_unmapped");
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, meaning the number of 32-bit RAM words, located at byte address 0.
REQ-002 SHALL have parameter MMIO_BASE, default 32'h1000_0000, meaning the byte base of the register window.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the TX FIFO entry count (power of 2, 2..8).
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports are listed below as name, direction, width, meaning.
REQ-005 clk  in  1  single clock, all state changes on the rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 mem_addr  in  32  CPU byte address; bits[1:0] ignored.
REQ-008 mem_wr_data  in  32  write data, already lane-aligned by the CPU.
REQ-009 mem_wr_sig  in  1  write strobe for the current cycle.
REQ-010 mem_be  in  4  byte-lane enables for writes; bit n gates byte n.
REQ-011 mem_rd_data  out  32  read data.
REQ-012 mem_err  out  1  one-cycle pulse on an unmapped access.
REQ-013 tx_data  out  8  FIFO head byte.
REQ-014 tx_valid  out  1  FIFO not empty.
REQ-015 tx_ready  in  1  consumer accepts the head byte when tx_valid&tx_ready.
REQ-016 gpio_out  out  32  GPIO register.
REQ-017 timer_irq  out  1  level interrupt.

Function
REQ-018 Reads SHALL be combinational: mem_rd_data reflects mem_addr in the same cycle, with zero wait states, because the CPU samples it into MEM/WB.
REQ-019 Writes SHALL commit on the rising edge where mem_wr_sig=1; for RAM, only lanes with mem_be=1 are updated.
REQ-020 The register map SHALL be, as offsets from MMIO_BASE: +0x00 GPIO (RW); +0x04 TXDATA (W, pushes bits[7:0]; reads 0); +0x08 STATUS (R: bit0 empty, bit1 full, bit2 overflow sticky, bits[7:4] count; write 1 to bit2 clears it); +0x0C CYCLE (R); +0x10 TIMECMP (RW).
REQ-021 MMIO writes SHALL ignore mem_be and use the full word.
REQ-022 An unmapped address SHALL make reads return 0 and drop writes; mem_err SHALL be registered high in the next cycle for exactly 1 cycle whenever the access is a write, or a read with a nonzero address.
REQ-023 A TXDATA push while the FIFO is full and no pop occurs in that cycle SHALL drop the byte and set overflow.
REQ-024 Push and pop in the same cycle SHALL both occur with count unchanged; this includes the full case, which SHALL set no overflow.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL use clog2(FIFO_DEPTH)+1 bits.
REQ-026 On an empty FIFO, tx_valid SHALL be 0, tx_data SHALL hold its last value, and a pop attempt SHALL have no effect.
REQ-027 tx_data/tx_valid SHALL change only on clock edges; a byte pushed into an empty FIFO SHALL be valid 1 cycle later.

Reset
REQ-028 On reset, the following SHALL take these values: FIFO empty, tx_valid=0, tx_data=0, overflow=0, gpio_out=0, mem_err=0, CYCLE=0, TIMECMP=32'hFFFF_FFFF, timer_irq=0.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 Reset asserted mid-transfer SHALL discard FIFO contents, and a write in the same cycle SHALL be ignored.

Configuration
REQ-031 Macro DMEM_TIMER_EN defined: CYCLE increments by 1 every non-reset cycle, wrapping at 2^32, and timer_irq = (CYCLE >= TIMECMP), registered.
REQ-032 Macro DMEM_TIMER_EN undefined: no CYCLE/TIMECMP flops exist, offsets 0x0C/0x10 read 0, writes there are ignored without error, and timer_irq is tied 0.

Structure
REQ-033 A shared package (dmem_pkg) SHALL hold the register offset constants, the STATUS bit positions, and the default MMIO_BASE.
REQ-034 The FIFO SHALL be a sub-module, tx_fifo, with push/pop/full/empty/count ports; RAM and decode SHALL stay in dmem_responder.

Verification
REQ-035 Write 32'hDEADBEEF to 0x10 with mem_be=4'b0101, having first filled the word with 0 -> read 0x10 = 32'h00AD00EF in the same cycle.
REQ-036 Push 0x41,0x42,0x43,0x44 with tx_ready=0 -> STATUS=0x42 (full, count 4); a 5th push -> STATUS bit2=1 and the FIFO is unchanged; then tx_ready=1 -> 0x41..0x44 come out in order, then empty.
REQ-037 With the FIFO full, push 0x55 while popping in the same cycle -> count stays 4, no overflow, and 0x55 emerges last.
REQ-038 Write 0x1234 to 0x0001_0000 (RAM_WORDS=1024) -> mem_err pulses 1 cycle, RAM unchanged, and a read of that address returns 0.
REQ-039 With DMEM_TIMER_EN defined, write TIMECMP=20 after reset -> timer_irq rises 1 cycle after CYCLE reaches 20; assert reset at CYCLE=25 -> timer_irq=0 and CYCLE=0 the next cycle.
REQ-040 Write GPIO=0xA5A5A5A5, then assert reset for 1 cycle -> gpio_out=0 while the RAM word written earlier still reads back its prior value.
